iq_byte_unpacker: RTL

Front-end unpacker that converts the raw interleaved 8-bit I/Q byte stream into the quantized 32-bit real/imag sample streams consumed by the complex FIR stage. It pops bytes from a single first-word-fall-through input FIFO and assembles each group of four bytes into one complex sample. It sign-extends and quantizes each component, then writes the real and imag parts to two output FIFOs in the same cycle. It is the producing end of the xreal/ximag FIFO pair that feeds the channel filter.

---
 rtl/iq_byte_unpacker_if.sv | 25 ++
 rtl/iq_byte_unpacker.sv | 90 +++++++++
 2 files changed

// File: rtl/iq_byte_unpacker_if.sv
// Handshake bundle between the input byte FIFO, the unpacker and the real/imag output FIFO pair.
// The master side is the unpacker; the slave side is the FIFO environment around it.
interface iq_byte_unpacker_if #(
  parameter int DATA_SIZE = 32
);
  logic [7:0]           in_dout;
  logic                 in_empty;
  logic                 in_rd_en;
  logic [DATA_SIZE-1:0] real_out_din;
  logic                 real_out_wr_en;
  logic                 real_out_full;
  logic [DATA_SIZE-1:0] imag_out_din;
  logic                 imag_out_wr_en;
  logic                 imag_out_full;

  modport master (
    input  in_dout, in_empty, real_out_full, imag_out_full,
    output in_rd_en, real_out_din, real_out_wr_en, imag_out_din, imag_out_wr_en
  );

  modport slave (
    output in_dout, in_empty, real_out_full, imag_out_full,
    input  in_rd_en, real_out_din, real_out_wr_en, imag_out_din, imag_out_wr_en
  );
endinterface

// File: rtl/iq_byte_unpacker.sv
// Pops interleaved I_lo, I_hi, Q_lo, Q_hi bytes and writes one quantized complex sample
// to the real/imag output FIFO pair, always as a single joint write.
module iq_byte_unpacker #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  iq_byte_unpacker_if.master   bus
);

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           byte_cnt;
  logic [7:0]           i_lo;
  logic [7:0]           q_lo;
  logic [DATA_SIZE-1:0] i_reg;
  logic [DATA_SIZE-1:0] q_reg;
  logic                 rd_en;
  logic                 wr_en;

  // Sign-extend the 16-bit component first so the arithmetic shift keeps negative values negative.
  function automatic logic [DATA_SIZE-1:0] quantize(input logic [7:0] hi, input logic [7:0] lo);
    logic signed [DATA_SIZE-1:0] ext;
    ext = DATA_SIZE'($signed({hi, lo}));
    return ext <<< BITS;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_READ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_READ: begin
        rd_en = !bus.in_empty;
        if (!bus.in_empty && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.real_out_full && !bus.imag_out_full) begin
          wr_en      = 1'b1;
          state_next = S_READ;
        end
      end
      default: state_next = S_READ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      i_lo     <= 8'd0;
      q_lo     <= 8'd0;
      i_reg    <= '0;
      q_reg    <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (!bus.in_empty) begin
            case (byte_cnt)
              2'd0:    i_lo  <= bus.in_dout;
              2'd1:    i_reg <= quantize(bus.in_dout, i_lo);
              2'd2:    q_lo  <= bus.in_dout;
              default: q_reg <= quantize(bus.in_dout, q_lo);
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: ;
        default: byte_cnt <= 2'd0;
      endcase
    end
  end

  assign bus.in_rd_en       = rd_en;
  assign bus.real_out_wr_en = wr_en;
  assign bus.imag_out_wr_en = wr_en;
  assign bus.real_out_din   = i_reg;
  assign bus.imag_out_din   = q_reg;

endmodule
